reaction_timebase: RTL and testbench
====================================

Name: reaction_timebase

Overview:
- Timing and stimulus source that answers the game-control FSM's timer interface.
- Provides three things:
  - a millisecond reaction timer driven by the FSM's reset/up/enable strobes;
  - a one-second-resolution game clock driven by game_reset/game_timer_enable;
  - a pseudo-random LED index for target selection.
- Sits between the board clock and the game FSM. It holds all counters the FSM only reads.

Parameters:
- CLK_FREQ_HZ, 50000000, board clock frequency.
- CLKS_PER_MS, CLK_FREQ_HZ/1000, prescaler terminal count. Must be ≥2. Benches override it to 4.
- MAX_MS, 2047, reaction timer saturation value.
- GAME_SECONDS, 60, game clock saturation value.
- LED_NUM, 18, number of target LEDs. Must satisfy 2^($clog2(LED_NUM)-1) < LED_NUM.
- LFSR_SEED, 16'hACE1, LFSR reset value. Must be non-zero.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- timer_reset  in  1  clear reaction timer and ms prescaler
- timer_load  in  1  load timer_value from timer_load_value
- timer_load_value  in  $clog2(MAX_MS)  load value
- timer_up  in  1  1 = count up, 0 = count down
- timer_enable  in  1  prescaler/count enable
- timer_value  out  $clog2(MAX_MS)  reaction timer, ms
- ms_tick  out  1  one-cycle pulse per enabled ms
- game_reset  in  1  clear game clock and its prescaler
- game_timer_enable  in  1  game clock run enable
- game_timer_value  out  $clog2(GAME_SECONDS+1)  elapsed seconds
- game_over  out  1  high while game_timer_value == GAME_SECONDS
- random_next  in  1  request new random index
- random_value  out  $clog2(LED_NUM)  LED index, always < LED_NUM

Behaviour:
- Reset (rst=1, sampled on posedge clk):
  - timer_value=0, ms_tick=0, ms prescaler=0.
  - game_timer_value=0, game_over=0, game ms counter=0, game prescaler=0.
  - LFSR=LFSR_SEED, random_value=0.
  - rst overrides every other input.
- Reaction timer priority per cycle: timer_reset > timer_load > count.
  - timer_reset: timer_value=0, prescaler=0, ms_tick=0 next cycle.
  - timer_load: timer_value=timer_load_value, prescaler=0. Load values above MAX_MS clamp to MAX_MS.
  - count: while timer_enable, the prescaler increments. At CLKS_PER_MS-1 it wraps to 0 and ms_tick pulses for exactly 1 cycle.
    - On that tick: up=1 gives timer_value+1, saturating at MAX_MS. up=0 gives timer_value-1, saturating at 0.
    - First tick occurs CLKS_PER_MS enabled cycles after reset/load.
  - timer_enable=0: prescaler holds, no tick, value holds.
  - timer_up is sampled only on tick cycles; mid-ms direction change is legal.
- Game clock has an independent ms prescaler (same CLKS_PER_MS), a 0..999 ms counter and the seconds counter.
  - Priority: game_reset > count.
  - Counting: while game_timer_enable and game_timer_value < GAME_SECONDS, each game ms wraps the ms counter. At 999→0 game_timer_value increments.
  - At GAME_SECONDS: the seconds counter and both prescalers freeze and game_over=1. game_over is registered, asserted the same cycle the value reaches GAME_SECONDS.
  - game_reset: all game counters = 0, game_over=0 next cycle.
  - game_timer_enable=0: everything holds.
- Random source: 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting every cycle regardless of other inputs.
  - Candidate c = lfsr[W-1:0], where W = $clog2(LED_NUM). If c ≥ LED_NUM, c = c - LED_NUM.
  - On random_next=1, random_value=c the following cycle; otherwise it holds.
  - random_next held high updates every cycle.
- All outputs are registered; no combinational input-to-output paths.

Optional Feature:
- Macro: RANDOM_NO_REPEAT_EN.
- Defined: on random_next, if c == current random_value, random_value = c+1, wrapping to 0 at LED_NUM. Consecutive sampled indices never repeat.
- Undefined: random_value = c unconditionally; repeats are permitted.
- Either way random_value < LED_NUM.

Test Plan:
- CLKS_PER_MS=4, rst; then timer_enable=1, timer_up=1 for 40 cycles -> 10 ms_tick pulses, timer_value=10. Then timer_reset for 1 cycle -> timer_value=0 next cycle, next tick 4 cycles after release.
- timer_load=1 with value 3, up=0, enable=1 for 20 cycles -> values 2,1,0 at cycles 4,8,12, then held at 0. Load 4000 -> timer_value=2047. Up-count from 2047 stays 2047.
- timer_reset and timer_load asserted in the same cycle with value 100 -> timer_value=0.
- CLKS_PER_MS=4, GAME_SECONDS=3, game_timer_enable=1 -> game_timer_value=1 at cycle 4000, 3 at 12000, game_over=1 from then, holding at 3 for 1000 further cycles. game_reset -> 0, game_over=0 next cycle.
- random_next pulsed 10000 times with LED_NUM=18 -> every random_value in 0..17 and all 18 values observed. With RANDOM_NO_REPEAT_EN, no two consecutive samples are equal.
- rst asserted mid-count (timer_value=7, game_timer_value=2) -> all outputs return to their reset values next cycle, and random_value=0.

Source files
------------

// File: rtl/reaction_timebase_if.sv
// Timer/random interface between the game-control FSM (master) and reaction_timebase (slave).
interface reaction_timebase_if #(
    parameter int TW = 11,
    parameter int GW = 6,
    parameter int RW = 5
);
    logic          timer_reset;
    logic          timer_load;
    logic [TW-1:0] timer_load_value;
    logic          timer_up;
    logic          timer_enable;
    logic [TW-1:0] timer_value;
    logic          ms_tick;
    logic          game_reset;
    logic          game_timer_enable;
    logic [GW-1:0] game_timer_value;
    logic          game_over;
    logic          random_next;
    logic [RW-1:0] random_value;

    modport master (
        output timer_reset, timer_load, timer_load_value, timer_up, timer_enable,
        output game_reset, game_timer_enable, random_next,
        input  timer_value, ms_tick, game_timer_value, game_over, random_value
    );

    modport slave (
        input  timer_reset, timer_load, timer_load_value, timer_up, timer_enable,
        input  game_reset, game_timer_enable, random_next,
        output timer_value, ms_tick, game_timer_value, game_over, random_value
    );
endinterface

// File: rtl/reaction_timebase.sv
// Millisecond reaction timer, seconds game clock and LFSR LED-index source for the game FSM.
// Optional macro RANDOM_NO_REPEAT_EN: consecutive sampled random indices never repeat.
module reaction_timebase #(
    parameter int          CLK_FREQ_HZ  = 50000000,
    parameter int          CLKS_PER_MS  = CLK_FREQ_HZ / 1000,
    parameter int          MAX_MS       = 2047,
    parameter int          GAME_SECONDS = 60,
    parameter int          LED_NUM      = 18,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input logic               clk,
    input logic               rst,
    reaction_timebase_if.slave bus
);
    localparam int TW = $clog2(MAX_MS);
    localparam int GW = $clog2(GAME_SECONDS + 1);
    localparam int RW = $clog2(LED_NUM);
    localparam int PW = $clog2(CLKS_PER_MS);

    localparam logic [PW-1:0] PS_LAST   = PW'(CLKS_PER_MS - 1);
    localparam logic [TW-1:0] TMAX      = TW'(MAX_MS);
    localparam logic [GW-1:0] GSEC_LAST = GW'(GAME_SECONDS - 1);
    localparam logic [GW-1:0] GSEC      = GW'(GAME_SECONDS);
    localparam logic [9:0]    MS_LAST   = 10'd999;

    // Reaction timer
    logic [PW-1:0] rt_ps;
    logic [TW-1:0] rt_val;
    logic          rt_tick;
    logic          rt_wrap;

    assign rt_wrap = (rt_ps == PS_LAST);

    always_ff @(posedge clk) begin
        if (rst || bus.timer_reset) begin
            rt_ps   <= '0;
            rt_val  <= '0;
            rt_tick <= 1'b0;
        end else if (bus.timer_load) begin
            rt_ps   <= '0;
            rt_tick <= 1'b0;
            rt_val  <= (int'(bus.timer_load_value) > MAX_MS) ? TMAX : bus.timer_load_value;
        end else if (bus.timer_enable) begin
            rt_tick <= rt_wrap;
            if (rt_wrap) begin
                rt_ps <= '0;
                if (bus.timer_up)
                    rt_val <= (rt_val == TMAX) ? TMAX : rt_val + 1'b1;
                else
                    rt_val <= (rt_val == '0) ? '0 : rt_val - 1'b1;
            end else begin
                rt_ps <= rt_ps + 1'b1;
            end
        end else begin
            rt_tick <= 1'b0;
        end
    end

    // Game clock; everything freezes once the seconds counter reaches GAME_SECONDS
    logic [PW-1:0] g_ps;
    logic [9:0]    g_ms;
    logic [GW-1:0] g_sec;
    logic          g_over;
    logic          g_run;
    logic          g_ms_wrap;

    assign g_run     = bus.game_timer_enable && (g_sec != GSEC);
    assign g_ms_wrap = (g_ps == PS_LAST);

    always_ff @(posedge clk) begin
        if (rst || bus.game_reset) begin
            g_ps   <= '0;
            g_ms   <= '0;
            g_sec  <= '0;
            g_over <= 1'b0;
        end else if (g_run) begin
            g_ps <= g_ms_wrap ? '0 : g_ps + 1'b1;
            if (g_ms_wrap) begin
                g_ms <= (g_ms == MS_LAST) ? '0 : g_ms + 1'b1;
                if (g_ms == MS_LAST) begin
                    g_sec  <= g_sec + 1'b1;
                    g_over <= (g_sec == GSEC_LAST);
                end
            end
        end
    end

    // Random index: Fibonacci LFSR x^16+x^14+x^13+x^11, folded once into 0..LED_NUM-1
    logic [15:0]   lfsr;
    logic          lfsr_fb;
    logic [RW-1:0] cand;
    logic [RW-1:0] pick;
    logic [RW-1:0] rnd;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_comb begin
        cand = lfsr[RW-1:0];
        if (int'(cand) >= LED_NUM)
            cand = cand - RW'(LED_NUM);
    end

`ifdef RANDOM_NO_REPEAT_EN
    always_comb begin
        pick = cand;
        if (cand == rnd)
            pick = (int'(cand) == LED_NUM - 1) ? '0 : cand + 1'b1;
    end
`else
    assign pick = cand;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
            rnd  <= '0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
            if (bus.random_next)
                rnd <= pick;
        end
    end

    assign bus.timer_value      = rt_val;
    assign bus.ms_tick          = rt_tick;
    assign bus.game_timer_value = g_sec;
    assign bus.game_over        = g_over;
    assign bus.random_value     = rnd;
endmodule

// File: tb/tb_reaction_timebase.sv
// Directed bench for reaction_timebase with an elapsed-cycle behavioural model checked every cycle.
module tb_reaction_timebase;
    localparam int          CPM     = 4;
    localparam int          MAX_MS  = 2047;
    localparam int          GS      = 3;
    localparam int          LEDS    = 18;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          TW      = $clog2(MAX_MS);
    localparam int          GW      = $clog2(GS + 1);
    localparam int          RW      = $clog2(LEDS);
    localparam int          CYC_SEC = CPM * 1000;

    logic clk = 1'b0;
    logic rst;

    reaction_timebase_if #(.TW(TW), .GW(GW), .RW(RW)) bus ();

    reaction_timebase #(
        .CLKS_PER_MS (CPM),
        .MAX_MS      (MAX_MS),
        .GAME_SECONDS(GS),
        .LED_NUM     (LEDS),
        .LFSR_SEED   (SEED)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: reaction timer from enabled cycles since last clear, game clock from total run cycles.
    bit          m_valid = 1'b0;
    int          m_rt_cnt, m_tv, m_tick, m_g_cnt, m_rv, m_c;
    logic [15:0] m_lfsr;

    always @(posedge clk) begin
        if (rst || bus.timer_reset) begin
            m_rt_cnt = 0; m_tv = 0; m_tick = 0;
        end else if (bus.timer_load) begin
            m_rt_cnt = 0; m_tick = 0;
            m_tv = (int'(bus.timer_load_value) > MAX_MS) ? MAX_MS : int'(bus.timer_load_value);
        end else if (bus.timer_enable) begin
            m_rt_cnt++;
            m_tick = (m_rt_cnt % CPM == 0) ? 1 : 0;
            if (m_tick == 1)
                m_tv = bus.timer_up ? ((m_tv + 1 > MAX_MS) ? MAX_MS : m_tv + 1)
                                    : ((m_tv - 1 < 0) ? 0 : m_tv - 1);
        end else begin
            m_tick = 0;
        end

        if (rst || bus.game_reset)
            m_g_cnt = 0;
        else if (bus.game_timer_enable && m_g_cnt < GS * CYC_SEC)
            m_g_cnt++;

        if (rst) begin
            m_valid = 1'b1;
            m_lfsr  = SEED;
            m_rv    = 0;
        end else begin
            m_c = int'(m_lfsr) % (1 << RW);
            if (m_c >= LEDS) m_c = m_c - LEDS;
`ifdef RANDOM_NO_REPEAT_EN
            if (m_c == m_rv) m_c = (m_c + 1) % LEDS;
`endif
            if (bus.random_next) m_rv = m_c;
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_timer_value", int'(bus.timer_value), m_tv);
            chk("cyc_ms_tick", int'(bus.ms_tick), m_tick);
            chk("cyc_game_value", int'(bus.game_timer_value), m_g_cnt / CYC_SEC);
            chk("cyc_game_over", int'(bus.game_over), (m_g_cnt / CYC_SEC == GS) ? 1 : 0);
            chk("cyc_random", int'(bus.random_value), m_rv);
        end
    end

    int       ticks;
    int       v, prev, nseen;
    bit [LEDS-1:0] seen;

    initial begin
        rst = 1'b1;
        bus.timer_reset = 1'b0; bus.timer_load = 1'b0; bus.timer_load_value = '0;
        bus.timer_up = 1'b0; bus.timer_enable = 1'b0;
        bus.game_reset = 1'b0; bus.game_timer_enable = 1'b0; bus.random_next = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_timer_value", int'(bus.timer_value), 0);
        chk("rst_ms_tick", int'(bus.ms_tick), 0);
        chk("rst_game_value", int'(bus.game_timer_value), 0);
        chk("rst_game_over", int'(bus.game_over), 0);
        chk("rst_random", int'(bus.random_value), 0);

        // 40 enabled up-count cycles -> 10 ticks
        rst = 1'b0; bus.timer_enable = 1'b1; bus.timer_up = 1'b1;
        ticks = 0;
        repeat (40) begin @(negedge clk); ticks += int'(bus.ms_tick); end
        chk("ticks_in_40", ticks, 10);
        chk("tv_after_40", int'(bus.timer_value), 10);

        bus.timer_reset = 1'b1;
        @(negedge clk);
        bus.timer_reset = 1'b0;
        chk("tv_after_treset", int'(bus.timer_value), 0);
        ticks = 0;
        repeat (3) begin @(negedge clk); ticks += int'(bus.ms_tick); end
        chk("no_tick_before_4", ticks, 0);
        @(negedge clk);
        chk("tick_at_4", int'(bus.ms_tick), 1);
        chk("tv_at_4", int'(bus.timer_value), 1);

        // Down-count from 3 saturating at 0
        bus.timer_up = 1'b0; bus.timer_load = 1'b1; bus.timer_load_value = TW'(3);
        @(negedge clk);
        bus.timer_load = 1'b0;
        chk("tv_load3", int'(bus.timer_value), 3);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 4)  chk("tv_down_c4", int'(bus.timer_value), 2);
            if (n == 8)  chk("tv_down_c8", int'(bus.timer_value), 1);
            if (n == 12) chk("tv_down_c12", int'(bus.timer_value), 0);
            if (n == 20) chk("tv_down_c20", int'(bus.timer_value), 0);
        end

        // 4000 does not fit the 11-bit load field; the largest loadable value is MAX_MS itself
        bus.timer_up = 1'b1; bus.timer_load = 1'b1; bus.timer_load_value = TW'(MAX_MS);
        @(negedge clk);
        bus.timer_load = 1'b0;
        chk("tv_load_max", int'(bus.timer_value), 2047);
        repeat (8) @(negedge clk);
        chk("tv_up_saturate", int'(bus.timer_value), 2047);

        bus.timer_reset = 1'b1; bus.timer_load = 1'b1; bus.timer_load_value = TW'(100);
        @(negedge clk);
        bus.timer_reset = 1'b0; bus.timer_load = 1'b0;
        chk("tv_reset_beats_load", int'(bus.timer_value), 0);

        // Game clock to saturation
        bus.timer_enable = 1'b0;
        bus.game_reset = 1'b1;
        @(negedge clk);
        bus.game_reset = 1'b0; bus.game_timer_enable = 1'b1;
        for (int n = 1; n <= 12000; n++) begin
            @(negedge clk);
            if (n == 3999) chk("gv_c3999", int'(bus.game_timer_value), 0);
            if (n == 4000) chk("gv_c4000", int'(bus.game_timer_value), 1);
            if (n == 11999) begin
                chk("gv_c11999", int'(bus.game_timer_value), 2);
                chk("over_c11999", int'(bus.game_over), 0);
            end
            if (n == 12000) begin
                chk("gv_c12000", int'(bus.game_timer_value), 3);
                chk("over_c12000", int'(bus.game_over), 1);
            end
        end
        repeat (1000) @(negedge clk);
        chk("gv_hold", int'(bus.game_timer_value), 3);
        chk("over_hold", int'(bus.game_over), 1);
        bus.game_reset = 1'b1; bus.game_timer_enable = 1'b0;
        @(negedge clk);
        bus.game_reset = 1'b0;
        chk("gv_after_greset", int'(bus.game_timer_value), 0);
        chk("over_after_greset", int'(bus.game_over), 0);

        // Random index range and coverage
        seen = '0; prev = -1;
        for (int i = 0; i < 10000; i++) begin
            bus.random_next = 1'b1;
            @(negedge clk);
            v = int'(bus.random_value);
            bus.random_next = 1'b0;
            chk("rand_in_range", (v < LEDS) ? 1 : 0, 1);
            if (v < LEDS) seen[v] = 1'b1;
`ifdef RANDOM_NO_REPEAT_EN
            if (i > 0) chk("rand_no_repeat", (v != prev) ? 1 : 0, 1);
`endif
            prev = v;
            @(negedge clk);
        end
        nseen = 0;
        for (int k = 0; k < LEDS; k++) nseen += int'(seen[k]);
        chk("rand_coverage", nseen, LEDS);

        // Mid-count reset
        bus.game_reset = 1'b1; bus.timer_load = 1'b1; bus.timer_load_value = TW'(7);
        @(negedge clk);
        bus.game_reset = 1'b0; bus.timer_load = 1'b0; bus.game_timer_enable = 1'b1;
        repeat (8000) @(negedge clk);
        chk("pre_rst_tv", int'(bus.timer_value), 7);
        chk("pre_rst_gv", int'(bus.game_timer_value), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus.game_timer_enable = 1'b0;
        chk("mid_rst_tv", int'(bus.timer_value), 0);
        chk("mid_rst_tick", int'(bus.ms_tick), 0);
        chk("mid_rst_gv", int'(bus.game_timer_value), 0);
        chk("mid_rst_over", int'(bus.game_over), 0);
        chk("mid_rst_random", int'(bus.random_value), 0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
